grant_stream_mux: RTL and testbench

Packet-aware stream multiplexer that sits directly downstream of the `arbiter` block.
- Presents each input port's `s_valid` to the arbiter as `request`.
- Takes the arbiter's `grant` / `grant_valid` / `grant_encoded` and forwards the granted port's packet, one beat per cycle, to a single output stream.
- Pulses `acknowledge` on the granted port's last beat, so the arbiter moves on.
- Intended pairing: arbiter built with ARB_BLOCK=1, ARB_BLOCK_ACK=1, ARB_TYPE_ROUND_ROBIN=1.

---
 rtl/grant_stream_mux.sv | 181 ++++++++++++++++++
 tb/tb_grant_stream_mux.sv | 538 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_stream_mux.sv
// grant_stream_mux: forwards whole packets from the port picked by an upstream
// round-robin arbiter onto a single output stream. Each packet's last beat
// pulses acknowledge so the arbiter can move on. The output stage is a main
// register plus a one-entry skid register.
// Optional feature macro: GRANT_STREAM_MUX_CHECK_EN adds a sticky grant_error
// output that flags a grant vector inconsistent with grant_encoded.
module grant_stream_mux #(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [PORTS-1:0]            s_valid,
  input  logic [PORTS-1:0]            s_last,
  output logic [PORTS-1:0]            s_ready,
  output logic [PORTS-1:0]            request,
  output logic [PORTS-1:0]            acknowledge,
  input  logic [PORTS-1:0]            grant,
  input  logic                        grant_valid,
  input  logic [$clog2(PORTS)-1:0]    grant_encoded,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready
`ifdef GRANT_STREAM_MUX_CHECK_EN
  ,
  output logic                        grant_error
`endif
);

  localparam int unsigned SelW = $clog2(PORTS);

  typedef enum logic [0:0] {StIdle, StFwd} state_e;

  state_e                  state_q, state_d;
  logic [SelW-1:0]         sel_q, sel_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic                    skid_last_q, skid_last_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;

  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_valid;
  logic                    sel_last;
  logic                    accept;

  assign request = s_valid;

  // Pick the selected port's beat; ready only depends on registered state.
  always_comb begin
    sel_data    = '0;
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    s_ready     = '0;
    acknowledge = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      if (sel_q == i[SelW-1:0]) begin
        sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        s_ready[i] = (state_q == StFwd) && !skid_valid_q;
      end
    end
    accept = sel_valid && (state_q == StFwd) && !skid_valid_q;
    for (int i = 0; i < int'(PORTS); i++) begin
      if (sel_q == i[SelW-1:0]) begin
        acknowledge[i] = accept && sel_last;
      end
    end
  end

  // Next-state for the packet FSM and the main/skid output buffer.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StFwd;
          sel_d   = grant_encoded;
        end
      end
      StFwd: begin
        if (accept && sel_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // While the skid entry is full no beat can be accepted, so only drain it.
    if (skid_valid_q) begin
      if (m_ready) begin
        m_data_d     = skid_data_q;
        m_last_d     = skid_last_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_valid_q || m_ready) begin
        m_valid_d = 1'b1;
        m_data_d  = sel_data;
        m_last_d  = sel_last;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = sel_data;
        skid_last_d  = sel_last;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // FSM state, selected port and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

`ifdef GRANT_STREAM_MUX_CHECK_EN
  localparam logic [PORTS-1:0] OneP = {{(PORTS-1){1'b0}}, 1'b1};

  logic grant_error_q, grant_error_d;
  logic grant_onehot;

  // Flag a grant vector that disagrees with grant_encoded when a packet starts.
  always_comb begin
    grant_onehot  = (grant != '0) && ((grant & (grant - OneP)) == '0);
    grant_error_d = grant_error_q;
    if ((state_q == StIdle) && grant_valid &&
        (!grant_onehot || (grant != (OneP << grant_encoded)))) begin
      grant_error_d = 1'b1;
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_error_q <= 1'b0;
    end else begin
      grant_error_q <= grant_error_d;
    end
  end

  assign grant_error = grant_error_q;
`else
  logic unused_grant;
  assign unused_grant = ^grant;
`endif

endmodule

// File: tb/tb_grant_stream_mux.sv
// Bench for grant_stream_mux: a round-robin arbiter model drives the grant
// side, per-port packet queues drive the inputs, and a scoreboard of accepted
// beats checks the output stream, acknowledge timing and buffering limits.
module tb_grant_stream_mux;
  localparam int unsigned PORTS = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = $clog2(PORTS);
  localparam logic [PORTS-1:0] OneP = {{(PORTS-1){1'b0}}, 1'b1};

  typedef logic [DW:0] beat_t;  // {last, data}

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [PORTS*DW-1:0]  s_data;
  logic [PORTS-1:0]     s_valid, s_last, s_ready, request, acknowledge, grant;
  logic                 grant_valid;
  logic [SW-1:0]        grant_encoded;
  logic [DW-1:0]        m_data;
  logic                 m_valid, m_last, m_ready;
`ifdef GRANT_STREAM_MUX_CHECK_EN
  logic                 grant_error;
`endif

  grant_stream_mux #(.PORTS(PORTS), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .request       (request),
    .acknowledge   (acknowledge),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_encoded (grant_encoded),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_ready       (m_ready)
`ifdef GRANT_STREAM_MUX_CHECK_EN
    ,
    .grant_error   (grant_error)
`endif
  );

  always #5 clk = ~clk;

  // Round-robin arbiter model: holds a grant until acknowledged, then
  // re-arbitrates on the same edge with the acknowledged port ranked last.
  logic          arb_gv;
  logic [SW-1:0] arb_idx, arb_last;
  int            arb_p;

  function automatic int rr_pick(input logic [PORTS-1:0] req, input int last);
    for (int k = 1; k <= int'(PORTS); k++) begin
      int p = (last + k) % int'(PORTS);
      if (req[p]) return p;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      arb_gv   <= 1'b0;
      arb_idx  <= '0;
      arb_last <= SW'(PORTS - 1);
    end else if (!arb_gv || acknowledge[arb_idx]) begin
      arb_p = rr_pick(request & ~acknowledge, int'(arb_last));
      if (arb_p >= 0) begin
        arb_gv   <= 1'b1;
        arb_idx  <= SW'(arb_p);
        arb_last <= SW'(arb_p);
      end else begin
        arb_gv <= 1'b0;
      end
    end
  end

  logic          ovr_en = 1'b0;
  logic          ovr_next = 1'b0;
  logic [PORTS-1:0] ovr_grant = '0;
  logic [SW-1:0] ovr_enc = '0;

  always_comb begin
    if (ovr_en) begin
      grant         = ovr_grant;
      grant_valid   = 1'b1;
      grant_encoded = ovr_enc;
    end else begin
      grant         = arb_gv ? (OneP << arb_idx) : '0;
      grant_valid   = arb_gv;
      grant_encoded = arb_idx;
    end
  end

  // Model state
  beat_t pq [PORTS][$];
  beat_t exp_q [$];
  beat_t out_log [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_pct = 100;
  int ready_pct = 100;
  int open_port = -1;
  int out_beats = 0;
  int out_pkts = 0;
  int in_beats = 0;
  int in_total = 0;
  int first_acc_cyc = -1;
  int last_ack_cyc = -1;
  bit gap_check = 1'b0;
  int ack_cnt [PORTS];

  function automatic bit pending();
    for (int i = 0; i < int'(PORTS); i++) if (pq[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_pkt(input int port, input int len, input logic [DW-1:0] base);
    for (int k = 0; k < len; k++) begin
      pq[port].push_back({(k == len - 1), base + DW'(k)});
      in_total++;
    end
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, update the model.
  task automatic cycle();
    logic [PORTS-1:0] acc, exp_ack;
    beat_t b;
    @(negedge clk);
    for (int i = 0; i < int'(PORTS); i++) begin
      if (pq[i].size() > 0) begin
        s_valid[i]         = (int'($urandom_range(99)) < valid_pct);
        s_data[i*DW +: DW] = pq[i][0][DW-1:0];
        s_last[i]          = pq[i][0][DW];
      end else begin
        s_valid[i]         = 1'b0;
        s_data[i*DW +: DW] = $urandom;
        s_last[i]          = 1'($urandom_range(1));
      end
    end
    m_ready = (int'($urandom_range(99)) < ready_pct);
    ovr_en = ovr_next;
    ovr_next = 1'b0;
    #1;
    cyc++;
    acc = s_valid & s_ready;
    exp_ack = acc & s_last;

    checks++;
    if (request !== s_valid) begin
      failures++;
      $display("FAIL request cyc=%0d got=%b want=%b", cyc, request, s_valid);
    end
    checks++;
    if (acknowledge !== exp_ack) begin
      failures++;
      $display("FAIL acknowledge cyc=%0d got=%b want=%b", cyc, acknowledge, exp_ack);
    end
    checks++;
    if ($countones(s_ready) > 1) begin
      failures++;
      $display("FAIL ready_onehot cyc=%0d got=%b want=at most one bit", cyc, s_ready);
    end
    checks++;
    if (m_valid !== (exp_q.size() != 0)) begin
      failures++;
      $display("FAIL m_valid cyc=%0d got=%b want=%0d", cyc, m_valid, exp_q.size() != 0);
    end
    checks++;
    if (exp_q.size() > 2) begin
      failures++;
      $display("FAIL buffered cyc=%0d got=%0d want<=2", cyc, exp_q.size());
    end
    if (exp_q.size() >= 2) begin
      checks++;
      if (s_ready !== '0) begin
        failures++;
        $display("FAIL ready_when_full cyc=%0d got=%b want=0", cyc, s_ready);
      end
    end
    if (m_valid === 1'b1 && exp_q.size() > 0) begin
      checks++;
      if ({m_last, m_data} !== exp_q[0]) begin
        failures++;
        $display("FAIL m_beat cyc=%0d got=%h want=%h", cyc, {m_last, m_data}, exp_q[0]);
      end
      if (m_ready) begin
        b = exp_q.pop_front();
        out_log.push_back(b);
        out_beats++;
        if (b[DW]) out_pkts++;
      end
    end

    for (int i = 0; i < int'(PORTS); i++) begin
      if (acc[i]) begin
        if (open_port >= 0) begin
          checks++;
          if (open_port != i) begin
            failures++;
            $display("FAIL interleave cyc=%0d got_port=%0d want_port=%0d", cyc, i, open_port);
          end
        end else if (gap_check && last_ack_cyc >= 0) begin
          checks++;
          if (cyc - last_ack_cyc !== 2) begin
            failures++;
            $display("FAIL packet_gap cyc=%0d got=%0d want=2", cyc, cyc - last_ack_cyc);
          end
        end
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        b = pq[i].pop_front();
        exp_q.push_back({s_last[i], s_data[i*DW +: DW]});
        in_beats++;
        if (s_last[i]) begin
          open_port = -1;
          ack_cnt[i]++;
          last_ack_cyc = cyc;
        end else begin
          open_port = i;
        end
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(PORTS); i++) begin
      pq[i].delete();
      ack_cnt[i] = 0;
    end
    exp_q.delete();
    out_log.delete();
    open_port = -1;
    out_beats = 0;
    out_pkts = 0;
    in_beats = 0;
    in_total = 0;
    first_acc_cyc = -1;
    last_ack_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_valid = '0;
    m_ready = 1'b0;
    ovr_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic drain(input string name);
    int budget = 3000;
    valid_pct = 100;
    ready_pct = 100;
    while ((pending() || exp_q.size() > 0) && budget > 0) begin
      cycle();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL %s_drain_timeout got=%0d_left want=0", name, exp_q.size());
    end
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    s_valid = '0;
    s_last = '0;
    s_data = '0;
    m_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (s_ready !== '0) begin failures++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
    checks++;
    if (acknowledge !== '0) begin
      failures++; $display("FAIL rst_ack got=%b want=0", acknowledge);
    end
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    checks++;
    if (m_data !== '0) begin failures++; $display("FAIL rst_m_data got=%h want=0", m_data); end
    checks++;
    if (m_last !== 1'b0) begin failures++; $display("FAIL rst_m_last got=%b want=0", m_last); end
`ifdef GRANT_STREAM_MUX_CHECK_EN
    checks++;
    if (grant_error !== 1'b0) begin
      failures++; $display("FAIL rst_grant_error got=%b want=0", grant_error);
    end
`endif
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_single_packet();
    int start;
    beat_t e;
    do_reset();
    add_pkt(2, 3, 32'hA0);
    start = cyc + 1;
    drain("single");
    checks++;
    if (first_acc_cyc - start !== 2) begin
      failures++;
      $display("FAIL grant_latency got=%0d want=2", first_acc_cyc - start);
    end
    checks++;
    if (out_log.size() !== 3) begin
      failures++; $display("FAIL single_count got=%0d want=3", out_log.size());
    end
    for (int k = 0; k < 3 && k < out_log.size(); k++) begin
      e = {(k == 2), DW'(32'hA0 + k)};
      checks++;
      if (out_log[k] !== e) begin
        failures++; $display("FAIL single_beat%0d got=%h want=%h", k, out_log[k], e);
      end
    end
    checks++;
    if (ack_cnt[2] !== 1 || ack_cnt[0] + ack_cnt[1] + ack_cnt[3] !== 0) begin
      failures++;
      $display("FAIL single_acks got=%0d/%0d/%0d/%0d want=0/0/1/0",
               ack_cnt[0], ack_cnt[1], ack_cnt[2], ack_cnt[3]);
    end
  endtask

  task automatic test_round_robin();
    int pkt, port, n, bt;
    beat_t e;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      add_pkt(0, 2, DW'((0 << 8) | (j << 4)));
      add_pkt(3, 2, DW'((3 << 8) | (j << 4)));
    end
    gap_check = 1'b1;
    drain("rr");
    gap_check = 1'b0;
    checks++;
    if (out_log.size() !== 16) begin
      failures++; $display("FAIL rr_count got=%0d want=16", out_log.size());
    end
    for (int k = 0; k < 16 && k < out_log.size(); k++) begin
      pkt  = k / 2;
      port = (pkt % 2 == 0) ? 0 : 3;
      n    = pkt / 2;
      bt   = k % 2;
      e = {(bt == 1), DW'((port << 8) | (n << 4) | bt)};
      checks++;
      if (out_log[k] !== e) begin
        failures++; $display("FAIL rr_beat%0d got=%h want=%h", k, out_log[k], e);
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t e;
    do_reset();
    add_pkt(1, 8, 32'hB0);
    valid_pct = 100;
    ready_pct = 100;
    for (int k = 0; k < 50 && out_beats < 2; k++) cycle();
    checks++;
    if (out_beats < 2) begin
      failures++; $display("FAIL bp_start got=%0d want>=2", out_beats);
    end
    ready_pct = 0;
    repeat (5) cycle();
    checks++;
    if (exp_q.size() !== 2) begin
      failures++; $display("FAIL bp_buffered got=%0d want=2", exp_q.size());
    end
    checks++;
    if (s_ready !== '0) begin
      failures++; $display("FAIL bp_s_ready got=%b want=0", s_ready);
    end
    drain("bp");
    checks++;
    if (out_log.size() !== 8) begin
      failures++; $display("FAIL bp_count got=%0d want=8", out_log.size());
    end
    for (int k = 0; k < 8 && k < out_log.size(); k++) begin
      e = {(k == 7), DW'(32'hB0 + k)};
      checks++;
      if (out_log[k] !== e) begin
        failures++; $display("FAIL bp_beat%0d got=%h want=%h", k, out_log[k], e);
      end
    end
  endtask

  task automatic test_single_beat_all();
    beat_t e;
    do_reset();
    for (int i = 0; i < int'(PORTS); i++) add_pkt(i, 1, DW'(32'hC0 + i));
    gap_check = 1'b1;
    drain("sb");
    gap_check = 1'b0;
    checks++;
    if (out_pkts !== 4) begin failures++; $display("FAIL sb_pkts got=%0d want=4", out_pkts); end
    for (int k = 0; k < int'(PORTS) && k < out_log.size(); k++) begin
      e = {1'b1, DW'(32'hC0 + k)};
      checks++;
      if (out_log[k] !== e || ack_cnt[k] !== 1) begin
        failures++;
        $display("FAIL sb_port%0d got=%h acks=%0d want=%h acks=1", k, out_log[k], ack_cnt[k], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_t e;
    do_reset();
    add_pkt(0, 4, 32'hD0);
    valid_pct = 100;
    ready_pct = 100;
    for (int k = 0; k < 50 && in_beats < 2; k++) cycle();
    @(negedge clk);
    rst = 1'b1;
    s_valid = '0;
    m_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_m got=%b/%h/%b want=0/0/0", m_valid, m_data, m_last);
    end
    checks++;
    if (s_ready !== '0 || acknowledge !== '0) begin
      failures++;
      $display("FAIL rstmid_s got=%b/%b want=0/0", s_ready, acknowledge);
    end
    rst = 1'b0;
    clear_model();
    add_pkt(1, 3, 32'hE0);
    drain("rstmid");
    checks++;
    if (out_log.size() !== 3 || ack_cnt[1] !== 1) begin
      failures++;
      $display("FAIL rstmid_count got=%0d acks=%0d want=3 acks=1", out_log.size(), ack_cnt[1]);
    end
    for (int k = 0; k < 3 && k < out_log.size(); k++) begin
      e = {(k == 2), DW'(32'hE0 + k)};
      checks++;
      if (out_log[k] !== e) begin
        failures++; $display("FAIL rstmid_beat%0d got=%h want=%h", k, out_log[k], e);
      end
    end
  endtask

  task automatic test_random();
    int p;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(9) == 0) begin
        p = int'($urandom_range(PORTS - 1));
        if (pq[p].size() < 16) add_pkt(p, int'($urandom_range(1, 5)), $urandom);
      end
      valid_pct = 70;
      ready_pct = 60;
      cycle();
    end
    drain("random");
    checks++;
    if (out_beats !== in_total) begin
      failures++; $display("FAIL random_count got=%0d want=%0d", out_beats, in_total);
    end
`ifdef GRANT_STREAM_MUX_CHECK_EN
    checks++;
    if (grant_error !== 1'b0) begin
      failures++; $display("FAIL random_grant_error got=%b want=0", grant_error);
    end
`endif
  endtask

`ifdef GRANT_STREAM_MUX_CHECK_EN
  task automatic test_grant_error();
    beat_t e;
    do_reset();
    add_pkt(2, 2, 32'hF0);
    ovr_grant = 4'b0001;
    ovr_enc = 2'd2;
    ovr_next = 1'b1;
    valid_pct = 100;
    ready_pct = 100;
    cycle();
    cycle();
    checks++;
    if (grant_error !== 1'b1) begin
      failures++; $display("FAIL gerr_set got=%b want=1", grant_error);
    end
    drain("gerr");
    checks++;
    if (grant_error !== 1'b1) begin
      failures++; $display("FAIL gerr_sticky got=%b want=1", grant_error);
    end
    for (int k = 0; k < 2; k++) begin
      e = {(k == 1), DW'(32'hF0 + k)};
      checks++;
      if (out_log.size() <= k || out_log[k] !== e) begin
        failures++; $display("FAIL gerr_beat%0d got_n=%0d want=%h", k, out_log.size(), e);
      end
    end
    do_reset();
    @(negedge clk);
    #1;
    checks++;
    if (grant_error !== 1'b0) begin
      failures++; $display("FAIL gerr_clear got=%b want=0", grant_error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_single_beat_all();
    test_reset_mid();
    test_random();
`ifdef GRANT_STREAM_MUX_CHECK_EN
    test_grant_error();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
